// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port round-robin arbiter/sequencer in front of the single-port
//   RegMemory data memory. Port 0 is the core load/store unit. Port 1 is the
//   debug/DMA loader. Each granted access is walked through RegMemory's
//   registered-address / negedge-write timing:
//     IDLE -> ADDR -> ACCESS -> RESP -> IDLE  (legal address, 4 cycles)
//     IDLE -> RESP -> IDLE                    (illegal address, 2 cycles)
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   req/wr/addr/wdata 0|1  requester inputs
//   ack/err/rdata 0|1      registered completion outputs; err and rdata are
//                          qualified by ack
//   memWrEn/memAddr/       to RegMemory isWrRegMem / addr / dataIn
//   memDataIn
//   memDataOut             from RegMemory regOut
//   busy                   1 whenever the sequencer is not in IDLE
//   state_dbg              current sequencer state
//                          (0 IDLE, 1 ADDR, 2 ACCESS, 3 RESP)
//
// Handshake: a requester raises req_k and holds wr_k/addr_k/wdata_k stable
// until it samples ack_k=1. ack_k is a single-cycle pulse. If req_k is still
// high in the IDLE cycle after RESP, a new transaction starts. The losing
// side of a tie is not acked and is picked up in the next IDLE cycle.
module dmem_arbiter #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int DMEMADDRBITS   = 13,
  parameter int DMEMWORDBITS   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0,
  input  logic                      wr0,
  input  logic [DATA_BIT_WIDTH-1:0] addr0,
  input  logic [DATA_BIT_WIDTH-1:0] wdata0,
  output logic                      ack0,
  output logic                      err0,
  output logic [DATA_BIT_WIDTH-1:0] rdata0,
  input  logic                      req1,
  input  logic                      wr1,
  input  logic [DATA_BIT_WIDTH-1:0] addr1,
  input  logic [DATA_BIT_WIDTH-1:0] wdata1,
  output logic                      ack1,
  output logic                      err1,
  output logic [DATA_BIT_WIDTH-1:0] rdata1,
  output logic                      memWrEn,
  output logic [DATA_BIT_WIDTH-1:0] memAddr,
  output logic [DATA_BIT_WIDTH-1:0] memDataIn,
  input  logic [DATA_BIT_WIDTH-1:0] memDataOut,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      prio_q, prio_d;
  logic                      port_q, port_d;
  logic                      wr_q, wr_d;
  logic [DATA_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic                      memwr_q, memwr_d;
  logic                      ack0_q, ack0_d, ack1_q, ack1_d;
  logic                      err0_q, err0_d, err1_q, err1_d;
  logic [DATA_BIT_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Arbitration signals (only meaningful in IDLE)
  logic                      any_req;
  logic                      grant;
  logic                      sel_wr;
  logic [DATA_BIT_WIDTH-1:0] sel_addr;
  logic [DATA_BIT_WIDTH-1:0] sel_wdata;
  logic                      sel_legal;

  // Address must fall inside the decoded window and be word aligned.
  function automatic logic addr_legal(input logic [DATA_BIT_WIDTH-1:0] a);
    return (a[DATA_BIT_WIDTH-1:DMEMADDRBITS] == '0) &&
           (a[DMEMWORDBITS-1:0] == '0);
  endfunction

  always_comb begin
    any_req   = req0 | req1;
    // On a tie the prio port wins; otherwise the single requester wins.
    grant     = (req0 && req1) ? prio_q : req1;
    sel_wr    = grant ? wr1    : wr0;
    sel_addr  = grant ? addr1  : addr0;
    sel_wdata = grant ? wdata1 : wdata0;
    sel_legal = addr_legal(sel_addr);
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    port_d   = port_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    memwr_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          port_d  = grant;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // prio always points away from the most recent winner.
          prio_d  = ~grant;
          if (sel_legal) begin
            state_d = S_ADDR;
          end else begin
            // Illegal address: answer immediately with err, memory untouched.
            state_d = S_RESP;
            if (grant) begin
              ack1_d = 1'b1;
              err1_d = 1'b1;
            end else begin
              ack0_d = 1'b1;
              err0_d = 1'b1;
            end
          end
        end
      end

      S_ADDR: begin
        // RegMemory captures memAddr/memDataIn at the end of this cycle;
        // the write strobe is raised for the following cycle only.
        state_d = S_ACCESS;
        memwr_d = wr_q;
      end

      S_ACCESS: begin
        // The write commits at this cycle's negedge; read data is valid now.
        state_d = S_RESP;
        if (port_q) begin
          ack1_d   = 1'b1;
          rdata1_d = wr_q ? '0 : memDataOut;
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = wr_q ? '0 : memDataOut;
        end
      end

      S_RESP: begin
        state_d  = S_IDLE;
        rdata0_d = '0;
        rdata1_d = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      port_q   <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      memwr_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      port_q   <= port_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      memwr_q  <= memwr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // memAddr/memDataIn hold the last latched request; harmless while memWrEn=0.
  assign memAddr   = addr_q;
  assign memDataIn = wdata_q;
  assign memWrEn   = memwr_q;
  assign ack0      = ack0_q;
  assign err0      = err0_q;
  assign rdata0    = rdata0_q;
  assign ack1      = ack1_q;
  assign err1      = err1_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule
